axi_lite_slave_regs: RTL

//  AXI4-Lite slave endpoint that sits downstream of the five AXI-Lite channel stages.
//  It consumes AW/W/AR, produces B/R, and holds NUM_REGS DATA_W-bit registers
//  (byte-strobed writes, readback). The register contents drive the design through o_regs.

---
 rtl/axi_lite_pkg.sv | 16 +
 rtl/axi_lite_wr_join.sv | 66 ++++++
 rtl/axi_lite_slave_regs.sv | 78 +++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes and byte-strobe merge shared by the AXI-Lite register slave.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) m[8*b +: 8] = data[8*b +: 8];
        return m;
    endfunction

endpackage

// File: rtl/axi_lite_wr_join.sv
// axi_lite_wr_join: one-deep AW and W holding slots joined into a single register commit plus B response.
module axi_lite_wr_join
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic [3:0]        w_strb,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [1:0]        b_resp,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [DATA_W-1:0] wr_data,
    output logic [3:0]        wr_strb
);

    logic              aw_held, w_held, hit, commit;
    logic [ADDR_W-1:0] addr_hold;

    assign aw_ready = rst_n && !aw_held;
    assign w_ready  = rst_n && !w_held;
    assign hit      = addr_hold < ADDR_W'(NUM_REGS * 4);
    // A pending B blocks the commit so the held pair waits for the response to drain
    assign commit   = aw_held && w_held && !b_valid;
    assign wr_en    = commit && hit;
    assign wr_idx   = addr_hold[2 +: IDX_W];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            addr_hold <= '0;
            wr_data   <= '0;
            wr_strb   <= '0;
            b_valid   <= 1'b0;
            b_resp    <= RESP_OKAY;
        end else begin
            if (commit) aw_held <= 1'b0;
            else if (aw_valid && aw_ready) begin
                aw_held   <= 1'b1;
                addr_hold <= aw_addr;
            end
            if (commit) w_held <= 1'b0;
            else if (w_valid && w_ready) begin
                w_held  <= 1'b1;
                wr_data <= w_data;
                wr_strb <= w_strb;
            end
            if (commit) begin
                b_valid <= 1'b1;
                b_resp  <= hit ? RESP_OKAY : RESP_SLVERR;
            end else if (b_ready) b_valid <= 1'b0;
        end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite slave with NUM_REGS byte-strobed registers and readback.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [ADDR_W-1:0]          AWADDR,
    input  logic [2:0]                 AWPROT,
    input  logic                       WVALID,
    output logic                       WREADY,
    input  logic [DATA_W-1:0]          WDATA,
    input  logic [3:0]                 WSTRB,
    output logic                       BVALID,
    input  logic                       BREADY,
    output logic [1:0]                 BRESP,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    input  logic [ADDR_W-1:0]          ARADDR,
    input  logic [2:0]                 ARPROT,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [DATA_W-1:0]          RDATA,
    output logic [1:0]                 RRESP,
    output logic [NUM_REGS*DATA_W-1:0] o_regs
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_en, ar_hit, unused;
    logic [IDX_W-1:0]  wr_idx, ar_idx;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_strb;

    assign unused = ^{AWPROT, ARPROT};

    axi_lite_wr_join #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)
    ) u_wr_join (
        .clk(ACLK), .rst_n(ARESETn),
        .aw_valid(AWVALID), .aw_ready(AWREADY), .aw_addr(AWADDR),
        .w_valid(WVALID), .w_ready(WREADY), .w_data(WDATA), .w_strb(WSTRB),
        .b_valid(BVALID), .b_ready(BREADY), .b_resp(BRESP),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_strb(wr_strb)
    );

    assign ARREADY = ARESETn && !RVALID;
    assign ar_hit  = ARADDR < ADDR_W'(NUM_REGS * 4);
    assign ar_idx  = ARADDR[2 +: IDX_W];

    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) regs[wr_idx] <= strb_merge(regs[wr_idx], wr_data, wr_strb);

    // Read samples the flops before a same-edge commit lands, so it returns the old value
    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
        end else if (ARVALID && ARREADY) begin
            RVALID <= 1'b1;
            RDATA  <= ar_hit ? regs[ar_idx] : '0;
            RRESP  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (RREADY) RVALID <= 1'b0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign o_regs[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule
